// File: rtl/fsm_state_monitor.sv
// rtl/fsm_state_monitor.sv - sticky-error observer for the S0->S1->S2->S0 sequencer
// Optional dwell timeout is compiled in with FSM_MON_DWELL_TIMEOUT_EN.
module fsm_state_monitor #(
   parameter int CNT_W     = 8,
   parameter int DWELL_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st_valid,
   input  logic [1:0]       st_code,
   input  logic             clr,
   output logic [1:0]       mon_state,
   output logic [1:0]       expected_next,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] lap_cnt,
   output logic             lap_pulse
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } mon_state_t;

   localparam logic [1:0] CODE_ILLEGAL = 2'd3;
   localparam logic [1:0] ERR_CODE     = 2'd1;
   localparam logic [1:0] ERR_TRANS    = 2'd2;
   localparam logic [1:0] ERR_DWELL    = 2'd3;

   mon_state_t state;
   logic [1:0] last;
   logic       dwell_timeout;

   function automatic logic [1:0] next_code(input logic [1:0] c);
      return (c == 2'd2) ? 2'd0 : c + 2'd1;
   endfunction

`ifdef FSM_MON_DWELL_TIMEOUT_EN
   localparam int DW_W = $clog2(DWELL_MAX + 1);

   logic [DW_W-1:0] dwell;

   // Counts repeats after the first sample, so DWELL_MAX samples means DWELL_MAX-1 repeats.
   assign dwell_timeout = (dwell == DW_W'(DWELL_MAX - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell <= '0;
      end else if (clr) begin
         dwell <= '0;
      end else if (st_valid && state == TRACK && st_code == last) begin
         if (dwell != DW_W'(DWELL_MAX))
            dwell <= dwell + DW_W'(1);
      end else if (st_valid && state != ERROR) begin
         dwell <= '0;
      end
   end
`else
   localparam int unused_dwell_max = DWELL_MAX;

   assign dwell_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last          <= 2'd0;
         expected_next <= 2'd0;
         err           <= 1'b0;
         err_code      <= 2'd0;
         lap_cnt       <= '0;
         lap_pulse     <= 1'b0;
      end else begin
         lap_pulse <= 1'b0;
         if (clr) begin
            state         <= IDLE;
            last          <= 2'd0;
            expected_next <= 2'd0;
            err           <= 1'b0;
            err_code      <= 2'd0;
            lap_cnt       <= '0;
         end else if (st_valid) begin
            case (state)
               IDLE: begin
                  if (st_code == CODE_ILLEGAL) begin
                     state    <= ERROR;
                     err      <= 1'b1;
                     err_code <= ERR_CODE;
                  end else begin
                     // First sample re-seeds tracking; no transition check against history.
                     state         <= TRACK;
                     last          <= st_code;
                     expected_next <= next_code(st_code);
                  end
               end
               TRACK: begin
                  if (st_code == CODE_ILLEGAL) begin
                     state    <= ERROR;
                     err      <= 1'b1;
                     err_code <= ERR_CODE;
                  end else if (st_code == last) begin
                     if (dwell_timeout) begin
                        state    <= ERROR;
                        err      <= 1'b1;
                        err_code <= ERR_DWELL;
                     end
                  end else if (st_code == next_code(last)) begin
                     last          <= st_code;
                     expected_next <= next_code(st_code);
                     if (last == 2'd2) begin
                        lap_cnt   <= lap_cnt + CNT_W'(1);
                        lap_pulse <= 1'b1;
                     end
                  end else begin
                     state    <= ERROR;
                     err      <= 1'b1;
                     err_code <= ERR_TRANS;
                  end
               end
               ERROR: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign mon_state = state;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// tb/tb_fsm_state_monitor.sv - directed self-checking bench for fsm_state_monitor
module tb_fsm_state_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st_valid = 1'b0;
   logic [1:0] st_code = 2'd0;
   logic       clr = 1'b0;
   logic [1:0] mon_state;
   logic [1:0] expected_next;
   logic       err;
   logic [1:0] err_code;
   logic [1:0] lap_cnt;
   logic       lap_pulse;

   int checks = 0;
   int errors = 0;

   fsm_state_monitor #(.CNT_W(2), .DWELL_MAX(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .st_valid      (st_valid),
      .st_code       (st_code),
      .clr           (clr),
      .mon_state     (mon_state),
      .expected_next (expected_next),
      .err           (err),
      .err_code      (err_code),
      .lap_cnt       (lap_cnt),
      .lap_pulse     (lap_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] code, input logic c);
      @(negedge clk);
      st_valid = v;
      st_code  = code;
      clr      = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".mon_state"}, 8'(mon_state), 8'd0);
      check({tag, ".expected_next"}, 8'(expected_next), 8'd0);
      check({tag, ".err"}, 8'(err), 8'd0);
      check({tag, ".err_code"}, 8'(err_code), 8'd0);
      check({tag, ".lap_cnt"}, 8'(lap_cnt), 8'd0);
      check({tag, ".lap_pulse"}, 8'(lap_pulse), 8'd0);
   endtask

   initial begin
      logic [1:0] seq [7];
      logic       pulse_exp [7];
      logic [1:0] lap_exp [4];
      seq       = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
      pulse_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      lap_exp   = '{2'd1, 2'd2, 2'd3, 2'd0};

      // Reset and normal sequence
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, seq[i], 1'b0);
         check($sformatf("norm.pulse%0d", i), 8'(lap_pulse), 8'(pulse_exp[i]));
      end
      check("norm.mon_state", 8'(mon_state), 8'd1);
      check("norm.err", 8'(err), 8'd0);
      check("norm.lap_cnt", 8'(lap_cnt), 8'd2);
      check("norm.expected_next", 8'(expected_next), 8'd1);
      step(1'b0, 2'd2, 1'b0);
      check("norm.gap_pulse", 8'(lap_pulse), 8'd0);
      check("norm.gap_lap", 8'(lap_cnt), 8'd2);
      check("norm.gap_exp", 8'(expected_next), 8'd1);

      // Illegal transition 0,1,0
      step(1'b0, 2'd0, 1'b1);
      check_all_zero("clr1");
      step(1'b1, 2'd0, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      check("trans.exp_before", 8'(expected_next), 8'd2);
      step(1'b1, 2'd0, 1'b0);
      check("trans.err", 8'(err), 8'd1);
      check("trans.err_code", 8'(err_code), 8'd2);
      check("trans.mon_state", 8'(mon_state), 8'd2);
      check("trans.expected_next", 8'(expected_next), 8'd2);
      step(1'b1, 2'd3, 1'b0);
      check("trans.sticky_code", 8'(err_code), 8'd2);
      check("trans.sticky_state", 8'(mon_state), 8'd2);
      step(1'b1, 2'd2, 1'b0);
      check("trans.frozen_exp", 8'(expected_next), 8'd2);

      // Illegal code as first sample, then clear and re-seed 2,0
      step(1'b0, 2'd0, 1'b1);
      step(1'b1, 2'd3, 1'b0);
      check("code.mon_state", 8'(mon_state), 8'd2);
      check("code.err_code", 8'(err_code), 8'd1);
      check("code.err", 8'(err), 8'd1);
      step(1'b0, 2'd0, 1'b1);
      check_all_zero("code.clr");
      step(1'b1, 2'd2, 1'b0);
      check("code.seed_exp", 8'(expected_next), 8'd0);
      step(1'b1, 2'd0, 1'b0);
      check("code.lap_cnt", 8'(lap_cnt), 8'd1);
      check("code.lap_pulse", 8'(lap_pulse), 8'd1);
      check("code.err", 8'(err), 8'd0);

      // Dwell behaviour on repeated S1 samples
      step(1'b0, 2'd0, 1'b1);
`ifdef FSM_MON_DWELL_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'd1, 1'b0);
         step(1'b0, 2'd1, 1'b0);
         check($sformatf("dwell.pre%0d", i), 8'(err), 8'd0);
      end
      step(1'b1, 2'd1, 1'b0);
      check("dwell.err_code", 8'(err_code), 8'd3);
      check("dwell.mon_state", 8'(mon_state), 8'd2);
`else
      for (int i = 0; i < 20; i++) step(1'b1, 2'd1, 1'b0);
      check("hold.err", 8'(err), 8'd0);
      check("hold.mon_state", 8'(mon_state), 8'd1);
      check("hold.expected_next", 8'(expected_next), 8'd2);
`endif

      // Lap counter wrap with CNT_W=2
      step(1'b0, 2'd0, 1'b1);
      step(1'b1, 2'd0, 1'b0);
      for (int l = 0; l < 4; l++) begin
         step(1'b1, 2'd1, 1'b0);
         step(1'b1, 2'd2, 1'b0);
         step(1'b1, 2'd0, 1'b0);
         check($sformatf("wrap.lap%0d", l), 8'(lap_cnt), 8'(lap_exp[l]));
      end
      check("wrap.err", 8'(err), 8'd0);

      // clr collides with a valid 2->0 sample
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd0, 1'b0);
      check("coll.lap_before", 8'(lap_cnt), 8'd1);
      step(1'b1, 2'd1, 1'b0);
      step(1'b1, 2'd2, 1'b0);
      step(1'b1, 2'd0, 1'b1);
      check_all_zero("coll");

      // Async reset mid-lap, then re-seed with S0
      step(1'b1, 2'd0, 1'b0);
      step(1'b1, 2'd1, 1'b0);
      check("rst.exp_before", 8'(expected_next), 8'd2);
      st_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 2'd0, 1'b0);
      check("reseed.mon_state", 8'(mon_state), 8'd1);
      check("reseed.err", 8'(err), 8'd0);
      check("reseed.expected_next", 8'(expected_next), 8'd1);
      check("reseed.lap_cnt", 8'(lap_cnt), 8'd0);

      step(1'b0, 2'd0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
